// File: rtl/node_rec_arbiter.sv
// Round-robin arbiter over per-bus CAN receive flags: captures rising edges as pending
// requests and grants them one at a time to the shared frame reader via valid/ack.
module node_rec_arbiter #(
  parameter int N_BUSES        = 32,
  parameter int ID_W           = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_BUSES-1:0] can_rec,
  input  logic               enable,
  input  logic               rec_ack,
  input  logic               overrun_clr,
  output logic               rec_valid,
  output logic [ID_W-1:0]    rec_id,
  output logic               rec_timeout,
  output logic [N_BUSES-1:0] pending,
  output logic [N_BUSES-1:0] overrun
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W-1:0] ID_LAST    = ID_W'(N_BUSES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    GRANT = 2'd2
  } state_t;

  state_t             state;
  logic [N_BUSES-1:0] can_rec_q;
  logic [N_BUSES-1:0] rise;
  logic [N_BUSES-1:0] clr;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    next_ptr;
  logic [TW-1:0]      timer;
  logic               hi_ok;
  logic               lo_ok;
  logic               hit_hi;
  logic               hit_lo;
  logic [ID_W-1:0]    hi_idx;
  logic [ID_W-1:0]    lo_idx;
  logic [ID_W-1:0]    pick;
  logic               pick_ok;

  // Edge detect and the pending-clear mask of an acknowledged grant.
  always_comb begin
    rise = can_rec & ~can_rec_q;
    clr  = '0;
    if (state == GRANT && rec_ack) begin
      clr[rec_id] = 1'b1;
    end else begin
      clr = '0;
    end
    if (rec_id == ID_LAST) begin
      next_ptr = '0;
    end else begin
      next_ptr = rec_id + ID_W'(1);
    end
  end

  // Round-robin search: lowest pending index at or above ptr, else lowest below ptr.
  // Descending loop so the lowest matching index is the last one written.
  always_comb begin
    hi_ok  = 1'b0;
    lo_ok  = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    for (int j = N_BUSES - 1; j >= 0; j--) begin
      hit_hi = pending[j] && (ID_W'(j) >= ptr);
      hit_lo = pending[j] && (ID_W'(j) <  ptr);
      hi_idx = hit_hi ? ID_W'(j) : hi_idx;
      lo_idx = hit_lo ? ID_W'(j) : lo_idx;
      hi_ok  = hi_ok | hit_hi;
      lo_ok  = lo_ok | hit_lo;
    end
    pick    = hi_ok ? hi_idx : lo_idx;
    pick_ok = hi_ok | lo_ok;
  end

  // Request capture; a new edge on the same cycle as a clear keeps the bit pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      can_rec_q <= '0;
      pending   <= '0;
      overrun   <= '0;
    end else begin
      can_rec_q <= can_rec;
      pending   <= (pending & ~clr) | rise;
      overrun   <= (overrun_clr ? '0 : overrun) | (rise & pending & ~clr);
    end
  end

  // Grant FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      timer       <= '0;
      rec_id      <= '0;
      rec_valid   <= 1'b0;
      rec_timeout <= 1'b0;
    end else begin
      rec_timeout <= 1'b0;
      case (state)
        IDLE: begin
          rec_valid <= 1'b0;
          if (enable && (|pending)) begin
            state <= SCAN;
          end else begin
            state <= IDLE;
          end
        end
        SCAN: begin
          if (pick_ok) begin
            rec_id    <= pick;
            timer     <= '0;
            rec_valid <= 1'b1;
            state     <= GRANT;
          end else begin
            rec_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        GRANT: begin
          if (rec_ack) begin
            rec_valid <= 1'b0;
            ptr       <= next_ptr;
            state     <= IDLE;
          end else if (timer == TIMER_LAST) begin
            // Abandon the grant; the request stays pending and is retried in turn.
            rec_timeout <= 1'b1;
            rec_valid   <= 1'b0;
            ptr         <= next_ptr;
            state       <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          rec_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
